// File: rtl/seg_pkg.sv
// Shared types and constants for the six-digit multiplexed seven-segment scanner.
package seg_pkg;

  localparam logic [7:0] SEG_OFF   = 8'hFF;
  localparam logic [5:0] SEL_OFF   = 6'h3F;
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [2:0] IDX_LEFT  = 3'd5;

  // Common-anode codes, bits 6:0 = g..a, active low
  localparam logic [6:0] DIG_0 = 7'h40;
  localparam logic [6:0] DIG_1 = 7'h79;
  localparam logic [6:0] DIG_2 = 7'h24;
  localparam logic [6:0] DIG_3 = 7'h30;
  localparam logic [6:0] DIG_4 = 7'h19;
  localparam logic [6:0] DIG_5 = 7'h12;
  localparam logic [6:0] DIG_6 = 7'h02;
  localparam logic [6:0] DIG_7 = 7'h78;
  localparam logic [6:0] DIG_8 = 7'h00;
  localparam logic [6:0] DIG_9 = 7'h10;

  typedef enum logic [1:0] {IDLE, BLANK, SHOW} state_e;

  typedef struct packed {
    logic [23:0] data;
    logic [5:0]  point;
    logic        lz_en;
  } disp_t;

endpackage

// File: rtl/seg_decode.sv
// BCD nibble to active-low seven-segment code; non-BCD nibbles and blanked digits go dark.
module seg_decode
  import seg_pkg::*;
(
  input  logic [3:0] nibble,
  input  logic       blank,
  output logic [6:0] seg
);

  // NOTE: seg gets a value before the case so no path leaves it unassigned (no latch).
  always_comb begin
    seg = SEG_BLANK;
    if (!blank) begin
      case (nibble)
        4'd0:    seg = DIG_0;
        4'd1:    seg = DIG_1;
        4'd2:    seg = DIG_2;
        4'd3:    seg = DIG_3;
        4'd4:    seg = DIG_4;
        4'd5:    seg = DIG_5;
        4'd6:    seg = DIG_6;
        4'd7:    seg = DIG_7;
        4'd8:    seg = DIG_8;
        4'd9:    seg = DIG_9;
        default: seg = SEG_BLANK;
      endcase
    end
  end

endmodule

// File: rtl/seg_led_scan_ctrl.sv
// Six-digit LED scanner: blank/show time slicing, leading-zero suppression and
// a shadow register that only reaches the display at frame boundaries.
module seg_led_scan_ctrl
  import seg_pkg::*;
#(
  parameter int CLK_DIV      = 50_000,
  parameter int BLANK_CYCLES = 500
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        en,
  input  logic        upd_valid,
  input  logic [23:0] data,
  input  logic [5:0]  point,
  input  logic        lz_en,
  output logic [5:0]  sel,
  output logic [7:0]  seg_led,
  output logic        frame_done
);

  localparam int SW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BW = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES) : 1;
  localparam logic [SW-1:0] SHOW_LAST  = SW'(CLK_DIV - 1);
  localparam logic [BW-1:0] BLANK_LAST = BW'(BLANK_CYCLES - 1);

  state_e        state_q, state_d;
  logic [2:0]    idx_q, idx_d;
  logic [SW-1:0] show_cnt_q, show_cnt_d;
  logic [BW-1:0] blank_cnt_q, blank_cnt_d;
  disp_t         shadow_q, active_q;
  logic          pending_q;

  logic          frame_end;
  logic          commit;
  logic [3:0]    cur_nib;
  logic          suppress;
  logic          dp_on;
  logic [6:0]    cur_seg;

  assign frame_end = (state_q == SHOW) && (idx_q == 3'd0) && (show_cnt_q == SHOW_LAST);
  // Idle display is dark, so a pending value may land immediately there
  assign commit    = pending_q && (frame_end || (state_q == IDLE));

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    show_cnt_d  = show_cnt_q;
    blank_cnt_d = blank_cnt_q;
    if (!en) begin
      state_d     = IDLE;
      idx_d       = IDX_LEFT;
      show_cnt_d  = '0;
      blank_cnt_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d     = BLANK;
          idx_d       = IDX_LEFT;
          blank_cnt_d = '0;
        end
        BLANK: begin
          if (blank_cnt_q == BLANK_LAST) begin
            state_d    = SHOW;
            show_cnt_d = '0;
          end else begin
            blank_cnt_d = blank_cnt_q + 1'b1;
          end
        end
        SHOW: begin
          if (show_cnt_q == SHOW_LAST) begin
            state_d     = BLANK;
            blank_cnt_d = '0;
            idx_d       = (idx_q == 3'd0) ? IDX_LEFT : idx_q - 3'd1;
          end else begin
            show_cnt_d = show_cnt_q + 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses <= so every register samples pre-edge values.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q     <= IDLE;
      idx_q       <= IDX_LEFT;
      show_cnt_q  <= '0;
      blank_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      show_cnt_q  <= show_cnt_d;
      blank_cnt_q <= blank_cnt_d;
    end
  end

  // NOTE: display storage is reset so a freshly enabled scan shows zeros, not garbage.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      shadow_q  <= '0;
      active_q  <= '0;
      pending_q <= 1'b0;
    end else begin
      if (commit) active_q <= shadow_q;
      if (upd_valid) begin
        shadow_q  <= {data, point, lz_en};
        pending_q <= 1'b1;
      end else if (commit) begin
        pending_q <= 1'b0;
      end
    end
  end

  // A digit is suppressed when it and every digit to its left are zero
  assign cur_nib  = 4'(active_q.data >> {idx_q, 2'b00});
  assign suppress = active_q.lz_en && (idx_q != 3'd0) &&
                    ((active_q.data >> {idx_q, 2'b00}) == 24'd0);
  assign dp_on    = |(active_q.point & (6'b1 << idx_q));

  seg_decode u_decode (
    .nibble (cur_nib),
    .blank  (suppress),
    .seg    (cur_seg)
  );

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      sel        <= SEL_OFF;
      seg_led    <= SEG_OFF;
      frame_done <= 1'b0;
    end else begin
      frame_done <= frame_end;
      if (state_q == SHOW) begin
        sel     <= ~(6'b1 << idx_q);
        seg_led <= {~dp_on, cur_seg};
      end else begin
        sel     <= SEL_OFF;
        seg_led <= SEG_OFF;
      end
    end
  end

endmodule

// File: tb/tb_seg_led_scan_ctrl.sv
// Self-checking bench for seg_led_scan_ctrl: a frame-position model predicts every output cycle.
module tb_seg_led_scan_ctrl;

  localparam int CD    = 4;
  localparam int BC    = 2;
  localparam int DIG   = CD + BC;
  localparam int FRAME = 6 * DIG;

  logic        sys_clk = 1'b0;
  logic        sys_rst;
  logic        en;
  logic        upd_valid;
  logic [23:0] data;
  logic [5:0]  point;
  logic        lz_en;
  logic [5:0]  sel;
  logic [7:0]  seg_led;
  logic        frame_done;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int last_fd = -1;

  // Reference model: displayed value, pending value and scan position in steps since enable
  logic [23:0] a_data, s_data;
  logic [5:0]  a_pt, s_pt;
  logic        a_lz, s_lz, m_pend;
  bit          m_run;
  int          m_step;
  logic [5:0]  exp_sel;
  logic [7:0]  exp_seg;
  logic        exp_fd;

  always #5 sys_clk = ~sys_clk;

  seg_led_scan_ctrl #(.CLK_DIV(CD), .BLANK_CYCLES(BC)) dut (
    .sys_clk    (sys_clk),
    .sys_rst    (sys_rst),
    .en         (en),
    .upd_valid  (upd_valid),
    .data       (data),
    .point      (point),
    .lz_en      (lz_en),
    .sel        (sel),
    .seg_led    (seg_led),
    .frame_done (frame_done)
  );

  function automatic logic [6:0] digit_code(input logic [3:0] n);
    case (n)
      4'd0: return 7'h40;
      4'd1: return 7'h79;
      4'd2: return 7'h24;
      4'd3: return 7'h30;
      4'd4: return 7'h19;
      4'd5: return 7'h12;
      4'd6: return 7'h02;
      4'd7: return 7'h78;
      4'd8: return 7'h00;
      4'd9: return 7'h10;
      default: return 7'h7F;
    endcase
  endfunction

  function automatic logic [23:0] rnd_data();
    logic [23:0] d;
    d = 24'($urandom);
    d = d >> (4 * $urandom_range(0, 6));
    return d;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    a_data = '0; a_pt = '0; a_lz = 1'b0;
    s_data = '0; s_pt = '0; s_lz = 1'b0;
    m_pend = 1'b0; m_run = 1'b0; m_step = 0;
    exp_sel = 6'h3F; exp_seg = 8'hFF; exp_fd = 1'b0;
  endtask

  // Called once per rising edge: outputs after the edge describe the cycle that just ended
  task automatic model_edge(input bit upd, input logic [23:0] d, input logic [5:0] pt, input bit lz);
    int  p;
    int  i;
    bit  boundary;
    logic sup;
    exp_sel  = 6'h3F;
    exp_seg  = 8'hFF;
    exp_fd   = 1'b0;
    boundary = 1'b0;
    if (m_run) begin
      p = m_step % FRAME;
      i = 5 - p / DIG;
      if ((p % DIG) >= BC) begin
        sup     = a_lz && (i > 0) && ((a_data >> (4 * i)) == 24'd0);
        exp_sel = ~(6'b1 << i);
        exp_seg = {~a_pt[i], sup ? 7'h7F : digit_code(a_data[4*i +: 4])};
      end
      boundary = (p == FRAME - 1);
      exp_fd   = boundary;
    end
    if (m_pend && (boundary || !m_run)) begin
      a_data = s_data; a_pt = s_pt; a_lz = s_lz;
      m_pend = 1'b0;
    end
    if (upd) begin
      s_data = d; s_pt = pt; s_lz = lz;
      m_pend = 1'b1;
    end
    if (en) begin
      m_step = m_run ? m_step + 1 : 0;
      m_run  = 1'b1;
    end else begin
      m_run  = 1'b0;
    end
  endtask

  // Entered and left at a falling edge; compares all outputs for the new cycle
  task automatic tick(input bit upd, input logic [23:0] d, input logic [5:0] pt, input bit lz);
    upd_valid = upd;
    data      = d;
    point     = pt;
    lz_en     = lz;
    @(posedge sys_clk);
    model_edge(upd, d, pt, lz);
    cyc++;
    @(negedge sys_clk);
    upd_valid = 1'b0;
    check($sformatf("sel@%0d", cyc), 32'(sel), 32'(exp_sel));
    check($sformatf("seg@%0d", cyc), 32'(seg_led), 32'(exp_seg));
    check($sformatf("fd@%0d", cyc), 32'(frame_done), 32'(exp_fd));
    if (frame_done === 1'b1) begin
      if (last_fd >= 0) check($sformatf("fd_period@%0d", cyc), 32'(cyc - last_fd), 32'(FRAME));
      last_fd = cyc;
    end
  endtask

  task automatic tick0();
    tick(1'b0, 24'd0, 6'd0, 1'b0);
  endtask

  task automatic run_to_show();
    for (int c = 0; c < FRAME && !(m_run && (m_step % DIG) == BC + 1); c++) tick0();
  endtask

  initial begin
    sys_rst = 1'b1; en = 1'b0; upd_valid = 1'b0;
    data = '0; point = '0; lz_en = 1'b0;
    model_reset();
    #3;
    check("rst_sel", 32'(sel), 32'h3F);
    check("rst_seg", 32'(seg_led), 32'hFF);
    check("rst_fd", 32'(frame_done), 32'h0);
    repeat (2) @(negedge sys_clk);
    sys_rst = 1'b0;

    // Load while idle, then scan two frames of 123456
    tick(1'b1, 24'h123456, 6'd0, 1'b0);
    tick0();
    en = 1'b1;
    repeat (2 * FRAME) tick0();

    // Mid-frame update must wait for the next frame boundary
    repeat (10) tick0();
    tick(1'b1, 24'h987650, 6'b100001, 1'b0);
    repeat (2 * FRAME) tick0();

    // Leading-zero suppression with a decimal point on digit 2
    tick(1'b1, 24'h000705, 6'b000100, 1'b1);
    repeat (2 * FRAME) tick0();

    // Random updates at random positions within each frame
    for (int f = 0; f < 12; f++) begin
      int at;
      at = $urandom_range(0, FRAME - 1);
      for (int c = 0; c < FRAME; c++) begin
        if (c == at) tick(1'b1, rnd_data(), 6'($urandom), 1'($urandom));
        else         tick0();
      end
    end

    // Update coincident with a frame-boundary commit
    tick(1'b1, 24'h111111, 6'b010101, 1'b0);
    for (int c = 0; c < FRAME && (m_step % FRAME) != FRAME - 1; c++) tick0();
    tick(1'b1, 24'h000042, 6'b000000, 1'b1);
    repeat (2 * FRAME + 2) tick0();

    // Drop enable mid-show: dark from the following cycle, restart at digit 5
    run_to_show();
    en = 1'b0;
    tick0();
    tick0();
    check("en_off_sel", 32'(sel), 32'h3F);
    check("en_off_seg", 32'(seg_led), 32'hFF);
    last_fd = -1;
    repeat (3) tick0();
    en = 1'b1;
    repeat (FRAME + DIG) tick0();

    // Asynchronous reset mid-show
    run_to_show();
    #2;
    sys_rst = 1'b1;
    model_reset();
    #1;
    check("rst_async_sel", 32'(sel), 32'h3F);
    check("rst_async_seg", 32'(seg_led), 32'hFF);
    check("rst_async_fd", 32'(frame_done), 32'h0);
    @(negedge sys_clk);
    last_fd = -1;
    sys_rst = 1'b0;
    repeat (BC + 1) tick0();
    tick0();
    check("restart_idx5_sel", 32'(sel), 32'h1F);
    check("restart_zero_seg", 32'(seg_led), 32'hC0);
    repeat (FRAME + DIG) tick0();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
